// File: rtl/jk_cmd_sequencer.sv
// rtl/jk_cmd_sequencer.sv - FIFO-buffered J/K command sequencer; optional shadow checker under JK_SEQ_SHADOW_EN
module jk_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [CNT_W-1:0]         cmd_rpt,
    output logic                     j,
    output logic                     k,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    input  logic                     q_fb,
    output logic                     mismatch
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2 + CNT_W;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    logic [EW-1:0]    mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             j_q, j_d, k_q, k_d;
    logic             empty, full, push, pop;
    logic [EW-1:0]    head;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign head      = mem_q[rd_ptr_q[AW-1:0]];
    assign level     = wr_ptr_q - rd_ptr_q;
    assign busy      = (state_q == RUN) || !empty;
    assign j         = j_q;
    assign k         = k_q;

    // Command storage; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {cmd_op, cmd_rpt};
        end
    end

    // Next-state: load a new command whenever idle or the current one has expired.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        j_d     = j_q;
        k_d     = k_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                end else begin
                    j_d = 1'b0;
                    k_d = 1'b0;
                end
            end
            RUN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!empty) begin
                    pop = 1'b1;
                end else begin
                    j_d     = 1'b0;
                    k_d     = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase
        if (pop) begin
            {j_d, k_d} = head[EW-1:CNT_W];
            cnt_d      = head[CNT_W-1:0];
            state_d    = RUN;
        end
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    end

    // State, counter, drive and pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            j_q      <= 1'b0;
            k_q      <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            j_q      <= j_d;
            k_q      <= k_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

`ifdef JK_SEQ_SHADOW_EN
    logic sq_q, sq_valid_q, mismatch_q;

    assign mismatch = mismatch_q;

    // Shadow flip-flop follows JK rules; compare only once a set/clear has defined it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sq_q       <= 1'b0;
            sq_valid_q <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            if (sq_valid_q && (q_fb != sq_q)) begin
                mismatch_q <= 1'b1;
            end
            case ({j_q, k_q})
                2'b01:   sq_q <= 1'b0;
                2'b10:   sq_q <= 1'b1;
                2'b11:   sq_q <= ~sq_q;
                default: sq_q <= sq_q;
            endcase
            if (j_q ^ k_q) begin
                sq_valid_q <= 1'b1;
            end
        end
    end
`else
    logic unused_q_fb;
    assign unused_q_fb = q_fb;
    assign mismatch    = 1'b0;
`endif
endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// tb/tb_jk_cmd_sequencer.sv - directed and random checks of jk_cmd_sequencer against a queue model
module tb_jk_cmd_sequencer;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [3:0] cmd_rpt = 4'd0;
    logic       j, k, busy, mismatch;
    logic [2:0] level;
    logic       q_fb;
    logic       ff_q = 1'b0;
    logic       force0 = 1'b0;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [1:0] op;
        logic [3:0] rpt;
    } cmd_t;

    cmd_t       mq[$];
    logic [1:0] m_out = 2'b00;
    int         m_left = 0;
    bit         m_run = 0;
    logic       m_mis = 1'b0;
    logic       m_sq = 1'b0;
    bit         m_sv = 0;
    logic [1:0] seen [6];
    logic [1:0] want [6];

    always #5 clk = ~clk;

    // Behavioural JK flip-flop standing in for the real downstream stage.
    always @(posedge clk) ff_q <= j ? (k ? ~ff_q : 1'b1) : (k ? 1'b0 : ff_q);
    assign q_fb = force0 ? 1'b0 : ff_q;

    jk_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rpt(cmd_rpt), .j(j), .k(k), .busy(busy),
        .level(level), .q_fb(q_fb), .mismatch(mismatch)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_out = 2'b00; m_left = 0; m_run = 0;
        m_mis = 1'b0; m_sq = 1'b0; m_sv = 0;
    endtask

    // One clock edge of the reference: current command lasts rpt+1 cycles, then the queue head takes over.
    task automatic model_edge();
        bit   acc;
        cmd_t c;
        acc = cmd_valid && (mq.size() < DEPTH);
`ifdef JK_SEQ_SHADOW_EN
        if (m_sv && (q_fb !== m_sq)) m_mis = 1'b1;
        if (m_out == 2'b01) m_sq = 1'b0;
        else if (m_out == 2'b10) m_sq = 1'b1;
        else if (m_out == 2'b11) m_sq = ~m_sq;
        if (m_out == 2'b01 || m_out == 2'b10) m_sv = 1;
`endif
        if (m_run && m_left > 0) begin
            m_left--;
        end else if (mq.size() > 0) begin
            c = mq.pop_front();
            m_out = c.op; m_left = int'(c.rpt); m_run = 1;
        end else begin
            m_out = 2'b00; m_run = 0;
        end
        if (acc) begin
            c.op = cmd_op; c.rpt = cmd_rpt;
            mq.push_back(c);
        end
    endtask

    task automatic check_all();
        chk("j", {31'd0, j}, {31'd0, m_out[1]});
        chk("k", {31'd0, k}, {31'd0, m_out[0]});
        chk("busy", {31'd0, busy}, {31'd0, (m_run || mq.size() > 0)});
        chk("level", {29'd0, level}, mq.size());
        chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, (mq.size() < DEPTH)});
        chk("mismatch", {31'd0, mismatch}, {31'd0, m_mis});
    endtask

    task automatic tick(input bit v, input logic [1:0] op, input logic [3:0] rpt);
        cmd_valid = v; cmd_op = op; cmd_rpt = rpt;
        model_edge();
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check_all();
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_j", {31'd0, j}, 32'd0);
        chk("rst_k", {31'd0, k}, 32'd0);
        chk("rst_level", {29'd0, level}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_mismatch", {31'd0, mismatch}, 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        do_reset();

        // Single set, rpt=0: latency and one-cycle drive.
        tick(1, 2'b10, 4'd0);
        chk("t1_e1_j", {31'd0, j}, 32'd0);
        chk("t1_e1_level", {29'd0, level}, 32'd1);
        tick(0, 2'b00, 4'd0);
        chk("t1_e2_jk", {30'd0, j, k}, 32'h2);
        chk("t1_e2_busy", {31'd0, busy}, 32'd1);
        tick(0, 2'b00, 4'd0);
        chk("t1_e3_jk", {30'd0, j, k}, 32'h0);
        chk("t1_e3_busy", {31'd0, busy}, 32'd0);

        // Back-to-back clear x3 then toggle x2 with no gap.
        want[0] = 2'b01; want[1] = 2'b01; want[2] = 2'b01;
        want[3] = 2'b11; want[4] = 2'b11; want[5] = 2'b00;
        tick(1, 2'b01, 4'd2);
        tick(1, 2'b11, 4'd1);
        seen[0] = {j, k};
        for (int i = 1; i < 6; i++) begin
            tick(0, 2'b00, 4'd0);
            seen[i] = {j, k};
        end
        for (int i = 0; i < 6; i++) chk($sformatf("t2_seq%0d", i), {30'd0, seen[i]}, {30'd0, want[i]});
        for (int i = 0; i < 3; i++) tick(0, 2'b00, 4'd0);

        // Fill the FIFO behind a long hold; fifth command must be refused.
        tick(1, 2'b00, 4'd15);
        tick(0, 2'b00, 4'd0);
        tick(1, 2'b01, 4'd1);
        tick(1, 2'b10, 4'd0);
        tick(1, 2'b11, 4'd2);
        tick(1, 2'b10, 4'd1);
        chk("t3_level_full", {29'd0, level}, 32'd4);
        chk("t3_ready_full", {31'd0, cmd_ready}, 32'd0);
        tick(1, 2'b11, 4'd3);
        chk("t3_level_still", {29'd0, level}, 32'd4);
        for (int i = 0; i < 40; i++) tick(0, 2'b00, 4'd0);
        chk("t3_drained", {29'd0, level}, 32'd0);

        // Reset mid-run with three entries queued.
        tick(1, 2'b10, 4'd15);
        tick(1, 2'b01, 4'd1);
        tick(1, 2'b11, 4'd1);
        tick(1, 2'b10, 4'd1);
        tick(0, 2'b00, 4'd0);
        chk("t4_level_pre", {29'd0, level}, 32'd3);
        do_reset();
        for (int i = 0; i < 20; i++) begin
            tick(0, 2'b00, 4'd0);
            chk("t4_no_drive", {30'd0, j, k}, 32'd0);
        end

        // Shadow tracking: set then three toggles, then force q_fb low.
        tick(1, 2'b10, 4'd0);
        tick(1, 2'b11, 4'd0);
        tick(1, 2'b11, 4'd0);
        tick(1, 2'b11, 4'd0);
        for (int i = 0; i < 6; i++) tick(0, 2'b00, 4'd0);
        chk("t5_no_mismatch", {31'd0, mismatch}, 32'd0);
        tick(1, 2'b10, 4'd0);
        for (int i = 0; i < 3; i++) tick(0, 2'b00, 4'd0);
        force0 = 1'b1;
        for (int i = 0; i < 4; i++) tick(0, 2'b00, 4'd0);
`ifdef JK_SEQ_SHADOW_EN
        chk("t5_mismatch_set", {31'd0, mismatch}, 32'd1);
`else
        chk("t5_mismatch_tied", {31'd0, mismatch}, 32'd0);
`endif
        do_reset();
        force0 = 1'b0;

        // Random traffic across many pointer wraps.
        for (int i = 0; i < 300; i++) begin
            tick($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
        end
        for (int i = 0; i < 80; i++) tick(0, 2'b00, 4'd0);
        chk("rand_idle_busy", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
